data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter LATENCY, default 2, meaning the number of BUSY wait cycles per access (legal range 0..15).
REQ-002 The block SHALL have parameter DEPTH_LOG2, default 6, meaning log2 of the number of 32-bit words stored (64).
REQ-003 The block SHALL have port clock, input, 1, meaning the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-005 The block SHALL have port mem_read, input, 1, meaning the pipeline MEM-stage load request.
REQ-006 The block SHALL have port mem_write, input, 1, meaning the pipeline MEM-stage store request.
REQ-007 The block SHALL have port addr, input, 32, meaning the byte address.
REQ-008 The block SHALL have port wdata, input, 32, meaning the store data.
REQ-009 The block SHALL have port rdata, output, 32, meaning the registered load data.
REQ-010 The block SHALL have port mem_stall, output, 1, meaning hold PC, IF/ID, ID/EX and EX/MEM this cycle.
REQ-011 The block SHALL have port ready, output, 1, meaning the access completes this cycle.
REQ-012 The block SHALL have port misaligned, output, 1, meaning the completing access had addr[1:0] != 0.

Function
REQ-013 The block SHALL implement states IDLE, BUSY and DONE, plus a 4-bit wait counter.
REQ-014 req SHALL be defined as mem_read | mem_write; in IDLE with req=1, addr, wdata, the op and the misaligned flag SHALL be captured at the clock edge.
REQ-015 After capture, the next state SHALL be BUSY with counter = LATENCY-1 when LATENCY > 0, and DONE when LATENCY = 0.
REQ-016 In BUSY, the counter SHALL decrement each cycle, and the state SHALL move to DONE on the edge where the counter equals 0.
REQ-017 From DONE, the next state SHALL be IDLE unconditionally; req SHALL NOT be sampled in DONE, so a held request is never re-accepted.
REQ-018 mem_stall SHALL be combinational: 1 when (IDLE & req) or BUSY, else 0.
REQ-019 ready SHALL equal 1 exactly in DONE (a one-cycle pulse), giving completion at cycle LATENCY+1 after the request is first seen in IDLE.
REQ-020 A store SHALL commit to the array at the edge entering DONE.
REQ-021 A load SHALL register the word into rdata at the edge entering DONE; rdata SHALL hold until the next completing load.
REQ-022 The word index SHALL be the captured addr[DEPTH_LOG2+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-023 For a misaligned access, the store SHALL be suppressed, rdata SHALL load 0 for a read, and misaligned SHALL be 1 during DONE only; timing SHALL be unchanged.
REQ-024 If mem_read and mem_write are both 1 at capture, the access SHALL be treated as a store.
REQ-025 Deassertion of req or changes to addr/wdata during BUSY SHALL be ignored; the captured access SHALL complete.
REQ-026 Back-to-back accesses SHALL be accepted from IDLE in the cycle after DONE, giving a minimum spacing of LATENCY+2 cycles.

Reset
REQ-027 While reset=0, the block SHALL force state IDLE, counter 0, rdata 0, ready 0, misaligned 0 and all array words 0, asynchronously.
REQ-028 A reset during BUSY SHALL abort the access, with no store committed and no ready pulse.
REQ-029 After reset deasserts, a request present in IDLE SHALL be accepted at the first rising edge.

Verification
REQ-030 LATENCY=2: store addr 0x10, wdata 0xDEADBEEF -> mem_stall 1 for 3 cycles, ready in cycle 3, then load 0x10 -> rdata 0xDEADBEEF in its DONE cycle.
REQ-031 LATENCY=0: load addr 0x0 after reset -> mem_stall 1 for 1 cycle, ready next cycle, rdata 0x00000000.
REQ-032 Misaligned store addr 0x13, wdata 0x1234 -> misaligned 1 with ready, and a later load of 0x10 returns the prior value unchanged.
REQ-033 Request held high through DONE -> exactly one ready pulse, then re-acceptance in IDLE counted as a new access (pipeline drops req in real use).
REQ-034 Reset asserted in BUSY of a store to 0x20 with 0xA5A5A5A5 -> no ready pulse, and a load of 0x20 returns 0.
REQ-035 DEPTH_LOG2=6: store 0x100 with 0x77 -> load 0x0 returns 0x77 (index wrap).

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Multi-cycle data memory model for a pipeline MEM stage. A load or store is
// captured in IDLE. The block waits LATENCY busy cycles, then completes in DONE
// with a one-cycle ready pulse. mem_stall holds the upstream pipeline until then.

module data_mem_responder #(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_stall,
    output logic        ready,
    output logic        misaligned
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam bit ZERO_LATENCY = (LATENCY == 0);
    localparam logic [3:0] LATENCY_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]  wait_count;
    logic [3:0]  wait_count_next;

    logic [DEPTH_LOG2-1:0] cap_index;
    logic [31:0] cap_wdata;
    logic        cap_write;
    logic        cap_mis;

    logic [31:0] mem [DEPTH];

    logic        req;
    logic        accept;
    logic        finish;

    logic [DEPTH_LOG2-1:0] eff_index;
    logic [31:0] eff_wdata;
    logic        eff_write;
    logic        eff_mis;

    logic        unused_addr_bits;

    assign req    = mem_read | mem_write;
    assign accept = (state == IDLE) && req;

    // Upper address bits are intentionally ignored, so the index wraps.
    assign unused_addr_bits = ^addr[31:DEPTH_LOG2+2];

    // With zero latency the access completes on the capture edge itself.
    // The live inputs must then be used instead of the captured copies.
    assign eff_index = (state == IDLE) ? addr[DEPTH_LOG2+1:2] : cap_index;
    assign eff_wdata = (state == IDLE) ? wdata                : cap_wdata;
    assign eff_write = (state == IDLE) ? mem_write            : cap_write;
    assign eff_mis   = (state == IDLE) ? (addr[1:0] != 2'b00) : cap_mis;

    assign ready      = (state == DONE);
    assign misaligned = (state == DONE) && cap_mis;

    // State and wait-counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wait_count <= 4'd0;
        end else begin
            state      <= state_next;
            wait_count <= wait_count_next;
        end
    end

    // Next-state logic, stall generation and detection of the edge that
    // enters DONE (where the array write and the rdata load take place).
    always_comb begin
        state_next      = state;
        wait_count_next = wait_count;
        mem_stall       = 1'b0;
        finish          = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    mem_stall = 1'b1;
                    if (ZERO_LATENCY) begin
                        state_next = DONE;
                        finish     = 1'b1;
                    end else begin
                        state_next      = BUSY;
                        wait_count_next = LATENCY_M1;
                    end
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                if (wait_count == 4'd0) begin
                    state_next = DONE;
                    finish     = 1'b1;
                end else begin
                    wait_count_next = wait_count - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the access when it is accepted; a store wins if both ops are set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cap_index <= '0;
            cap_wdata <= 32'd0;
            cap_write <= 1'b0;
            cap_mis   <= 1'b0;
        end else if (accept) begin
            cap_index <= addr[DEPTH_LOG2+1:2];
            cap_wdata <= wdata;
            cap_write <= mem_write;
            cap_mis   <= (addr[1:0] != 2'b00);
        end
    end

    // Word array: cleared by reset, written by aligned stores entering DONE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (finish && eff_write && !eff_mis) begin
            mem[eff_index] <= eff_wdata;
        end
    end

    // Load data register: updated only by completing loads, held otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= 32'd0;
        end else if (finish && !eff_write) begin
            rdata <= eff_mis ? 32'd0 : mem[eff_index];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
// Self-checking bench: a LATENCY=2 instance driven with directed and random
// accesses against an array-based reference model. A LATENCY=0 instance covers
// the zero-wait case.

module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        mem_read  = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr      = 32'd0;
    logic [31:0] wdata     = 32'd0;
    logic [31:0] rdata;
    logic        mem_stall;
    logic        ready;
    logic        misaligned;

    logic        z_read  = 1'b0;
    logic        z_write = 1'b0;
    logic [31:0] z_addr  = 32'd0;
    logic [31:0] z_wdata = 32'd0;
    logic [31:0] z_rdata;
    logic        z_stall;
    logic        z_ready;
    logic        z_mis;

    int total  = 0;
    int passed = 0;

    logic [31:0] model_mem [64];
    logic [31:0] model_rdata;

    data_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .mem_stall  (mem_stall),
        .ready      (ready),
        .misaligned (misaligned)
    );

    data_mem_responder #(.LATENCY(0), .DEPTH_LOG2(6)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .mem_read   (z_read),
        .mem_write  (z_write),
        .addr       (z_addr),
        .wdata      (z_wdata),
        .rdata      (z_rdata),
        .mem_stall  (z_stall),
        .ready      (z_ready),
        .misaligned (z_mis)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic model_reset();
        foreach (model_mem[i]) model_mem[i] = 32'd0;
        model_rdata = 32'd0;
    endtask

    // One access on the LATENCY=2 instance. It starts at the next negedge and
    // returns during the DONE cycle with the request dropped.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input bit scramble, input string tag);
        int cycles = 0;
        int stall_cycles = 0;
        bit seen = 0;
        logic exp_mis;
        logic [5:0] idx;
        @(negedge clock);
        mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        #1;
        while (cycles < 40) begin
            if (ready === 1'b1) begin
                seen = 1;
                break;
            end
            if (mem_stall === 1'b1) stall_cycles++;
            @(negedge clock);
            if (scramble) begin
                mem_read = 1'b0; mem_write = 1'b0; addr = $urandom; wdata = $urandom;
            end
            #1;
            cycles++;
        end
        exp_mis = (a[1:0] != 2'b00);
        idx = a[7:2];
        if (wr) begin
            if (!exp_mis) model_mem[idx] = wd;
        end else begin
            model_rdata = exp_mis ? 32'd0 : model_mem[idx];
        end
        total++;
        if (seen !== 1'b1) $display("[TB] FAIL %s ready_timeout: got no ready, expected ready within 40 cycles", tag);
        else passed++;
        total++;
        if (cycles !== LAT + 1) $display("[TB] FAIL %s ready_cycle: got %0d expected %0d", tag, cycles, LAT + 1);
        else passed++;
        total++;
        if (stall_cycles !== LAT + 1) $display("[TB] FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles, LAT + 1);
        else passed++;
        total++;
        if (mem_stall !== 1'b0) $display("[TB] FAIL %s stall_in_done: got %b expected 0", tag, mem_stall);
        else passed++;
        total++;
        if (misaligned !== exp_mis) $display("[TB] FAIL %s misaligned: got %b expected %b", tag, misaligned, exp_mis);
        else passed++;
        total++;
        if (rdata !== model_rdata) $display("[TB] FAIL %s rdata: got %h expected %h", tag, rdata, model_rdata);
        else passed++;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        total++;
        if (rdata !== 32'd0) $display("[TB] FAIL reset_rdata: got %h expected 0", rdata);
        else passed++;
        total++;
        if ({ready, misaligned, mem_stall} !== 3'b000)
            $display("[TB] FAIL reset_flags: got %b expected 000", {ready, misaligned, mem_stall});
        else passed++;
        total++;
        if ({z_ready, z_mis, z_stall} !== 3'b000)
            $display("[TB] FAIL reset_flags_lat0: got %b expected 000", {z_ready, z_mis, z_stall});
        else passed++;
        @(negedge clock);
        reset = 1'b1;
        run_access(1'b1, 1'b0, $urandom & 32'hFFFF_FFFC, 32'd0, 1'b0, "reset_load");
    endtask

    task automatic test_latency_zero();
        logic [31:0] v;
        v = $urandom;
        @(negedge clock);
        z_read = 1'b1; z_addr = 32'h0;
        #1;
        total++;
        if ({z_stall, z_ready} !== 2'b10) $display("[TB] FAIL lat0_first_cycle: got stall,ready=%b expected 10", {z_stall, z_ready});
        else passed++;
        @(negedge clock);
        z_read = 1'b0;
        #1;
        total++;
        if ({z_stall, z_ready, z_mis} !== 3'b010) $display("[TB] FAIL lat0_done: got stall,ready,mis=%b expected 010", {z_stall, z_ready, z_mis});
        else passed++;
        total++;
        if (z_rdata !== 32'd0) $display("[TB] FAIL lat0_rdata_zero: got %h expected 0", z_rdata);
        else passed++;
        @(negedge clock);
        z_write = 1'b1; z_addr = 32'h44; z_wdata = v;
        @(negedge clock);
        z_write = 1'b0;
        #1;
        total++;
        if (z_ready !== 1'b1) $display("[TB] FAIL lat0_store_ready: got %b expected 1", z_ready);
        else passed++;
        @(negedge clock);
        z_read = 1'b1; z_addr = 32'h44;
        @(negedge clock);
        z_read = 1'b0;
        #1;
        total++;
        if (z_rdata !== v) $display("[TB] FAIL lat0_load_back: got %h expected %h", z_rdata, v);
        else passed++;
    endtask

    task automatic test_store_load();
        run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, "store_0x10");
        run_access(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, "load_0x10");
        total++;
        if (rdata !== 32'hDEADBEEF) $display("[TB] FAIL load_0x10_const: got %h expected deadbeef", rdata);
        else passed++;
    endtask

    task automatic test_misaligned();
        run_access(1'b0, 1'b1, 32'h13, 32'h1234, 1'b0, "mis_store_0x13");
        run_access(1'b1, 1'b0, 32'h10, 32'd0, 1'b0, "load_after_mis");
        total++;
        if (rdata !== 32'hDEADBEEF) $display("[TB] FAIL mis_store_suppressed: got %h expected deadbeef", rdata);
        else passed++;
        run_access(1'b1, 1'b0, 32'h11, 32'd0, 1'b0, "mis_load_0x11");
    endtask

    task automatic test_wrap();
        run_access(1'b0, 1'b1, 32'h100, 32'h77, 1'b0, "store_0x100");
        run_access(1'b1, 1'b0, 32'h0, 32'd0, 1'b0, "load_0x0_wrap");
        total++;
        if (rdata !== 32'h77) $display("[TB] FAIL wrap_const: got %h expected 00000077", rdata);
        else passed++;
    endtask

    task automatic test_dual_op();
        logic [31:0] v;
        v = $urandom;
        run_access(1'b1, 1'b1, 32'h2C, v, 1'b0, "dual_op_store");
        run_access(1'b1, 1'b0, 32'h2C, 32'd0, 1'b0, "dual_op_load");
    endtask

    task automatic test_held_request();
        int pulses = 0;
        int first = -1;
        int second = -1;
        logic [31:0] a;
        a = {$urandom_range(0, 63), 2'b00};
        @(negedge clock);
        mem_read = 1'b1; addr = a;
        #1;
        for (int c = 0; c < 2 * (LAT + 2); c++) begin
            if (ready === 1'b1) begin
                pulses++;
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (c < 2 * (LAT + 2) - 1) begin
                @(negedge clock);
                #1;
            end
        end
        mem_read = 1'b0;
        model_rdata = model_mem[a[7:2]];
        total++;
        if (pulses !== 2) $display("[TB] FAIL held_pulse_count: got %0d expected 2", pulses);
        else passed++;
        total++;
        if (first !== LAT + 1) $display("[TB] FAIL held_first_ready: got %0d expected %0d", first, LAT + 1);
        else passed++;
        total++;
        if (second !== 2 * LAT + 3) $display("[TB] FAIL held_second_ready: got %0d expected %0d", second, 2 * LAT + 3);
        else passed++;
        total++;
        if (rdata !== model_rdata) $display("[TB] FAIL held_rdata: got %h expected %h", rdata, model_rdata);
        else passed++;
    endtask

    task automatic test_idle();
        @(negedge clock);
        #1;
        total++;
        if ({mem_stall, ready, misaligned} !== 3'b000)
            $display("[TB] FAIL idle_flags: got %b expected 000", {mem_stall, ready, misaligned});
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [1:0]  off;
        int op;
        for (int n = 0; n < 24; n++) begin
            a = $urandom;
            off = 2'($urandom_range(1, 3));
            a[1:0] = ($urandom_range(0, 3) == 0) ? off : 2'b00;
            op = $urandom_range(0, 2);
            run_access(op != 1, op != 0, a, $urandom, $urandom_range(0, 1) == 1, "random");
        end
    endtask

    task automatic test_reset_busy();
        int pulses = 0;
        int cycles = 0;
        @(negedge clock);
        mem_write = 1'b1; addr = 32'h20; wdata = 32'hA5A5A5A5;
        @(negedge clock);
        mem_write = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        total++;
        if ({mem_stall, ready} !== 2'b00) $display("[TB] FAIL reset_busy_abort: got stall,ready=%b expected 00", {mem_stall, ready});
        else passed++;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            if (ready === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) $display("[TB] FAIL reset_busy_ready: got %0d pulses expected 0", pulses);
        else passed++;
        model_reset();
        mem_read = 1'b1; addr = 32'h20;
        @(negedge clock);
        reset = 1'b1;
        #1;
        while (ready !== 1'b1 && cycles < 40) begin
            @(negedge clock);
            #1;
            cycles++;
        end
        mem_read = 1'b0;
        total++;
        if (cycles !== LAT + 1) $display("[TB] FAIL post_reset_accept: got ready after %0d cycles expected %0d", cycles, LAT + 1);
        else passed++;
        total++;
        if (rdata !== 32'd0) $display("[TB] FAIL reset_busy_no_store: got %h expected 0", rdata);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_latency_zero();
        test_store_load();
        test_misaligned();
        test_wrap();
        test_dual_op();
        test_held_request();
        test_idle();
        test_back_to_back();
        test_reset_busy();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
